pcie_us_msi_sched: RTL and testbench
====================================

Name: pcie_us_msi_sched

Overview:
- Shares the UltraScale PCIe hard-IP MSI interrupt interface (cfg_interrupt_msi_*) among IRQ_COUNT internal interrupt sources.
- Latches source pulses into a pending register and picks one vector round-robin.
- Issues the vector as a one-cycle one-hot pulse, waits for sent/fail, and retries on fail or timeout.
- Sits between user logic (DMA engines, queue managers) and the PCIe core config ports, replacing direct tie-offs of the MSI outputs.

Parameters:
- IRQ_COUNT, 32: number of interrupt sources/vectors; 1..32.
- RETRY_DELAY, 64: idle cycles after a fail/timeout before the next issue; ≥1.
- SENT_TIMEOUT, 4096: cycles in WAIT with no sent/fail before treating the attempt as fail.

Ports:
- clk  in  1  core clock (user_clk domain).
- rst  in  1  synchronous active-high reset.
- irq  in  IRQ_COUNT  per-source request; any cycle high sets that pending bit (level or pulse both accepted).
- irq_pending  out  IRQ_COUNT  current pending register.
- busy  out  1  high in ISSUE, WAIT or BACKOFF.
- cfg_interrupt_msi_enable  in  4  bit 0 = MSI enabled for PF0.
- cfg_interrupt_msi_mmenable  in  12  bits [2:0] = log2 of allocated vectors for PF0.
- cfg_interrupt_msi_mask_update  in  1  mask-changed strobe from core.
- cfg_interrupt_msi_data  in  32  mask value when select=0.
- cfg_interrupt_msi_select  out  4  constant 0.
- cfg_interrupt_msi_int  out  32  one-hot issue pulse.
- cfg_interrupt_msi_sent  in  1  delivery success.
- cfg_interrupt_msi_fail  in  1  delivery failure.
- cfg_interrupt_msi_pending_status  out  32  constant 0.
- cfg_interrupt_msi_pending_status_data_enable  out  1  constant 0.
- cfg_interrupt_msi_pending_status_function_num  out  4  constant 0.
- cfg_interrupt_msi_attr  out  3  constant 0.
- cfg_interrupt_msi_tph_present  out  1  constant 0.
- cfg_interrupt_msi_tph_type  out  2  constant 0.
- cfg_interrupt_msi_tph_st_tag  out  9  constant 0.
- cfg_interrupt_msi_function_number  out  4  constant 0.

Behaviour:
- Reset: state IDLE, pending=0, rr pointer=0, counters=0, cfg_interrupt_msi_int=0, busy=0, mask register=0.
- Vector folding: source i maps to vector i & (2^mmen-1), where mmen = mmenable[2:0], saturated at 5. Folded vectors share one pending bit.
- Pending update each cycle: pending <= (pending & ~clr) | set_from_irq. Set wins over a same-cycle clear.
- eligible = pending & ~mask.
- IDLE: if msi_enable[0] && eligible!=0, select the lowest eligible index ≥ rr pointer, else wrap to the lowest eligible. Register it as cur, go to ISSUE. While msi_enable[0]=0, pending is retained and nothing is issued.
- ISSUE (exactly 1 cycle): cfg_interrupt_msi_int = 1<<cur; clear pending[cur] this cycle; go to WAIT. Latency from irq to int pulse is ≥2 cycles: one for pending, one for select.
- WAIT: int=0; timeout counter increments.
  - sent: rr pointer <= cur+1 mod IRQ_COUNT, go to IDLE.
  - fail or counter==SENT_TIMEOUT-1: re-set pending[cur], go to BACKOFF.
  - sent and fail in the same cycle: treated as sent.
- BACKOFF: count RETRY_DELAY cycles, then IDLE. The rr pointer is unchanged, so the failed vector retries first.
- New irq on cur while in WAIT: bit sets again and a second MSI follows after completion.
- msi_enable[0] dropping in WAIT/BACKOFF: sequence completes normally; no new issue until re-enabled.
- Only one MSI is outstanding at any time.

Optional Feature:
- PCIE_MSI_MASK_EN defined:
  - Mask register loads cfg_interrupt_msi_data on the cycle after mask_update.
  - Masked vectors stay pending but are not eligible; they are issued once unmasked.
- PCIE_MSI_MASK_EN undefined:
  - Mask is constant 0.
  - mask_update and cfg_interrupt_msi_data are ignored.

Decomposition:
- Package pcie_msi_pkg: state enum (IDLE, ISSUE, WAIT, BACKOFF), MSI_MAX_VECTORS=32, tie-off constants.
- Sub-module: rr_prio_sel, a combinational round-robin priority encoder (request vector, pointer -> index, valid).
- FSM, counters and pending register live in the top.

Test Plan:
- mmen=5, enable=1: pulse irq[3] for 1 cycle -> int=0x00000008 for exactly 1 cycle ≥2 cycles later; assert sent -> irq_pending=0, busy=0.
- irq[0], irq[5], irq[31] pulsed together, all sent -> int order 0x1, 0x20, 0x80000000; then pulse irq[0] and irq[5] again -> order 0x1, 0x20 (pointer wrapped).
- irq[2] issued, core asserts fail -> pending[2]=1, no int for RETRY_DELAY=64 cycles, then int=0x4 again.
- mmen=1 (2 vectors): pulse irq[6] -> int=0x1; pulse irq[7] -> int=0x2.
- enable=0, pulse irq[4] -> no int, pending[4]=1; set enable=1 -> int=0x10. Separately, no sent/fail for 4096 cycles -> retry path.
- PCIE_MSI_MASK_EN: mask_update with data=0x2, pulse irq[1] -> no issue; mask_update with data=0 -> int=0x2.

Source files
------------

// File: rtl/pcie_us_msi_sched_pkg.sv
// Shared types and constants for the UltraScale PCIe MSI scheduler.
// Holds the FSM state enum, the vector limit, tie-off values and the mmenable folding helper.
package pcie_msi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        BACKOFF = 2'd3
    } msi_state_e;

    localparam int MSI_MAX_VECTORS = 32;

    localparam logic [3:0]  MSI_SELECT_TIE         = 4'd0;
    localparam logic [31:0] MSI_PEND_STATUS_TIE    = 32'd0;
    localparam logic        MSI_PEND_DATA_EN_TIE   = 1'b0;
    localparam logic [3:0]  MSI_PEND_FUNC_NUM_TIE  = 4'd0;
    localparam logic [2:0]  MSI_ATTR_TIE           = 3'd0;
    localparam logic        MSI_TPH_PRESENT_TIE    = 1'b0;
    localparam logic [1:0]  MSI_TPH_TYPE_TIE       = 2'd0;
    localparam logic [8:0]  MSI_TPH_ST_TAG_TIE     = 9'd0;
    localparam logic [3:0]  MSI_FUNC_NUM_TIE       = 4'd0;

    // Mask applied to a source index to find its vector; mmenable saturates at 32 vectors.
    function automatic logic [4:0] fold_mask(input logic [2:0] mmen);
        logic [2:0] sat;
        sat = (mmen > 3'd5) ? 3'd5 : mmen;
        return 5'((6'd1 << sat) - 6'd1);
    endfunction

endpackage

// File: rtl/pcie_us_msi_sched_if.sv
// MSI sideband of the UltraScale PCIe hard IP (cfg_interrupt_msi_*).
// master = interrupt scheduler side, slave = PCIe core side.
interface pcie_us_msi_sched_if;

    logic [3:0]  cfg_interrupt_msi_enable;
    logic [11:0] cfg_interrupt_msi_mmenable;
    logic        cfg_interrupt_msi_mask_update;
    logic [31:0] cfg_interrupt_msi_data;
    logic [3:0]  cfg_interrupt_msi_select;
    logic [31:0] cfg_interrupt_msi_int;
    logic        cfg_interrupt_msi_sent;
    logic        cfg_interrupt_msi_fail;
    logic [31:0] cfg_interrupt_msi_pending_status;
    logic        cfg_interrupt_msi_pending_status_data_enable;
    logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
    logic [2:0]  cfg_interrupt_msi_attr;
    logic        cfg_interrupt_msi_tph_present;
    logic [1:0]  cfg_interrupt_msi_tph_type;
    logic [8:0]  cfg_interrupt_msi_tph_st_tag;
    logic [3:0]  cfg_interrupt_msi_function_number;

    modport master (
        input  cfg_interrupt_msi_enable,
        input  cfg_interrupt_msi_mmenable,
        input  cfg_interrupt_msi_mask_update,
        input  cfg_interrupt_msi_data,
        input  cfg_interrupt_msi_sent,
        input  cfg_interrupt_msi_fail,
        output cfg_interrupt_msi_select,
        output cfg_interrupt_msi_int,
        output cfg_interrupt_msi_pending_status,
        output cfg_interrupt_msi_pending_status_data_enable,
        output cfg_interrupt_msi_pending_status_function_num,
        output cfg_interrupt_msi_attr,
        output cfg_interrupt_msi_tph_present,
        output cfg_interrupt_msi_tph_type,
        output cfg_interrupt_msi_tph_st_tag,
        output cfg_interrupt_msi_function_number
    );

    modport slave (
        output cfg_interrupt_msi_enable,
        output cfg_interrupt_msi_mmenable,
        output cfg_interrupt_msi_mask_update,
        output cfg_interrupt_msi_data,
        output cfg_interrupt_msi_sent,
        output cfg_interrupt_msi_fail,
        input  cfg_interrupt_msi_select,
        input  cfg_interrupt_msi_int,
        input  cfg_interrupt_msi_pending_status,
        input  cfg_interrupt_msi_pending_status_data_enable,
        input  cfg_interrupt_msi_pending_status_function_num,
        input  cfg_interrupt_msi_attr,
        input  cfg_interrupt_msi_tph_present,
        input  cfg_interrupt_msi_tph_type,
        input  cfg_interrupt_msi_tph_st_tag,
        input  cfg_interrupt_msi_function_number
    );

endinterface

// File: rtl/pcie_us_msi_sched_rr_prio_sel.sv
// Combinational round-robin priority encoder: lowest request at or above the
// pointer, otherwise the lowest request overall.
module rr_prio_sel #(
    parameter int N     = 32,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;
    logic             hit_hi;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        idx_hi = '0;
        idx_lo = '0;
        hit_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_lo = IDX_W'(i);
                if (IDX_W'(i) >= ptr_i) begin
                    idx_hi = IDX_W'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        idx_o   = hit_hi ? idx_hi : idx_lo;
        valid_o = |req_i;
    end

endmodule

// File: rtl/pcie_us_msi_sched.sv
// Round-robin MSI scheduler sharing the UltraScale PCIe MSI port among IRQ_COUNT sources.
// Define PCIE_MSI_MASK_EN to honour the host MSI mask delivered via mask_update/data.
module pcie_us_msi_sched
    import pcie_msi_pkg::*;
#(
    parameter int IRQ_COUNT    = 32,
    parameter int RETRY_DELAY  = 64,
    parameter int SENT_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_COUNT-1:0] irq,
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic                 busy,
    pcie_us_msi_sched_if.master  msi
);

    localparam int IDX_W   = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
    localparam int CNT_MAX = (SENT_TIMEOUT > RETRY_DELAY) ? SENT_TIMEOUT : RETRY_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    msi_state_e                 state_q, state_d;
    logic [IRQ_COUNT-1:0]       pending_q, pending_d;
    logic [IDX_W-1:0]           cur_q, cur_d;
    logic [IDX_W-1:0]           rr_q, rr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [MSI_MAX_VECTORS-1:0] int_q, int_d;

    logic [IRQ_COUNT-1:0] set_irq;
    logic [IRQ_COUNT-1:0] retry_set;
    logic [IRQ_COUNT-1:0] clr;
    logic [IRQ_COUNT-1:0] mask;
    logic [IRQ_COUNT-1:0] eligible;
    logic [4:0]           fmask;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;

    assign fmask = fold_mask(msi.cfg_interrupt_msi_mmenable[2:0]);

    // Sources beyond the allocated vector count alias onto lower vectors.
    always_comb begin
        set_irq = '0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            if (irq[i]) set_irq[IDX_W'(i & int'(fmask))] = 1'b1;
        end
    end

`ifdef PCIE_MSI_MASK_EN
    logic                 mask_upd_q;
    logic [IRQ_COUNT-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_upd_q <= 1'b0;
            mask_q     <= '0;
        end else begin
            mask_upd_q <= msi.cfg_interrupt_msi_mask_update;
            if (mask_upd_q) mask_q <= msi.cfg_interrupt_msi_data[IRQ_COUNT-1:0];
        end
    end

    assign mask = mask_q;
`else
    assign mask = '0;
`endif

    assign eligible = pending_q & ~mask;

    rr_prio_sel #(
        .N     (IRQ_COUNT),
        .IDX_W (IDX_W)
    ) u_sel (
        .req_i   (eligible),
        .ptr_i   (rr_q),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        int_d     = '0;
        clr       = '0;
        retry_set = '0;
        unique case (state_q)
            IDLE: begin
                if (msi.cfg_interrupt_msi_enable[0] && sel_valid) begin
                    cur_d   = sel_idx;
                    int_d   = MSI_MAX_VECTORS'(1) << sel_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                clr[cur_q] = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // sent takes precedence over a simultaneous fail
                if (msi.cfg_interrupt_msi_sent) begin
                    rr_d    = (cur_q == IDX_W'(IRQ_COUNT - 1)) ? '0 : cur_q + IDX_W'(1);
                    state_d = IDLE;
                end else if (msi.cfg_interrupt_msi_fail || cnt_q == CNT_W'(SENT_TIMEOUT - 1)) begin
                    retry_set[cur_q] = 1'b1;
                    cnt_d            = '0;
                    state_d          = BACKOFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BACKOFF: begin
                if (cnt_q == CNT_W'(RETRY_DELAY - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~clr) | set_irq | retry_set;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
            int_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            int_q     <= int_d;
        end
    end

    assign irq_pending = pending_q;
    assign busy        = (state_q != IDLE);

    assign msi.cfg_interrupt_msi_int                           = int_q;
    assign msi.cfg_interrupt_msi_select                        = MSI_SELECT_TIE;
    assign msi.cfg_interrupt_msi_pending_status                = MSI_PEND_STATUS_TIE;
    assign msi.cfg_interrupt_msi_pending_status_data_enable    = MSI_PEND_DATA_EN_TIE;
    assign msi.cfg_interrupt_msi_pending_status_function_num   = MSI_PEND_FUNC_NUM_TIE;
    assign msi.cfg_interrupt_msi_attr                          = MSI_ATTR_TIE;
    assign msi.cfg_interrupt_msi_tph_present                   = MSI_TPH_PRESENT_TIE;
    assign msi.cfg_interrupt_msi_tph_type                      = MSI_TPH_TYPE_TIE;
    assign msi.cfg_interrupt_msi_tph_st_tag                    = MSI_TPH_ST_TAG_TIE;
    assign msi.cfg_interrupt_msi_function_number               = MSI_FUNC_NUM_TIE;

    logic unused_cfg;
    assign unused_cfg = ^{msi.cfg_interrupt_msi_enable[3:1], msi.cfg_interrupt_msi_mmenable[11:3],
                          msi.cfg_interrupt_msi_mask_update, msi.cfg_interrupt_msi_data};

endmodule

// File: tb/tb_pcie_us_msi_sched.sv
// Directed self-checking bench for pcie_us_msi_sched (IRQ_COUNT=32, RETRY_DELAY=64, SENT_TIMEOUT=4096).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pcie_us_msi_sched;

    localparam int IRQ_COUNT    = 32;
    localparam int RETRY_DELAY  = 64;
    localparam int SENT_TIMEOUT = 4096;

    logic                 clk;
    logic                 rst;
    logic [IRQ_COUNT-1:0] irq;
    logic [IRQ_COUNT-1:0] irq_pending;
    logic                 busy;

    int n_cmp;
    int n_err;

    pcie_us_msi_sched_if msi ();

    pcie_us_msi_sched #(
        .IRQ_COUNT    (IRQ_COUNT),
        .RETRY_DELAY  (RETRY_DELAY),
        .SENT_TIMEOUT (SENT_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .irq_pending (irq_pending),
        .busy        (busy),
        .msi         (msi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed running, required finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        irq = '0;
        msi.cfg_interrupt_msi_sent = 1'b0;
        msi.cfg_interrupt_msi_fail = 1'b0;
        msi.cfg_interrupt_msi_mask_update = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_irq(input logic [31:0] m);
        irq = m;
        @(negedge clk);
        irq = '0;
    endtask

    task automatic wait_int(input logic [31:0] exp, input string tag, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (msi.cfg_interrupt_msi_int == 32'd0 && n < budget);
        check(tag, msi.cfg_interrupt_msi_int, exp);
    endtask

    // One cycle after the pulse: the int must be gone; then drive the core's answer for one cycle.
    task automatic respond(input logic s, input logic f, input string tag);
        @(negedge clk);
        check({tag, " one-cycle int"}, msi.cfg_interrupt_msi_int, 32'd0);
        msi.cfg_interrupt_msi_sent = s;
        msi.cfg_interrupt_msi_fail = f;
        @(negedge clk);
        msi.cfg_interrupt_msi_sent = 1'b0;
        msi.cfg_interrupt_msi_fail = 1'b0;
    endtask

    task automatic quiet(input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (msi.cfg_interrupt_msi_int != 32'd0) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int n;
        int tot;
        n_cmp = 0;
        n_err = 0;
        msi.cfg_interrupt_msi_enable   = 4'h1;
        msi.cfg_interrupt_msi_mmenable = 12'd5;
        msi.cfg_interrupt_msi_data     = 32'd0;
        do_reset();

        // Reset state and tie-offs
        check("reset pending", irq_pending, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset int", msi.cfg_interrupt_msi_int, 32'd0);
        check("select tie", 32'(msi.cfg_interrupt_msi_select), 32'd0);
        check("pend status tie", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Single source, 2-cycle latency, re-request while waiting
        pulse_irq(32'h0000_0008);
        check("irq3 latency int", msi.cfg_interrupt_msi_int, 32'd0);
        check("irq3 pending", irq_pending, 32'h0000_0008);
        wait_int(32'h0000_0008, "irq3 int", 10, n);
        check("irq3 latency", 32'(n), 32'd1);
        @(negedge clk);
        check("irq3 one-cycle int", msi.cfg_interrupt_msi_int, 32'd0);
        check("irq3 cleared on issue", irq_pending, 32'd0);
        irq = 32'h0000_0008;
        @(negedge clk);
        irq = '0;
        check("irq3 re-set in wait", irq_pending, 32'h0000_0008);
        check("irq3 busy in wait", 32'(busy), 32'd1);
        msi.cfg_interrupt_msi_sent = 1'b1;
        @(negedge clk);
        msi.cfg_interrupt_msi_sent = 1'b0;
        check("irq3 busy after sent", 32'(busy), 32'd0);
        wait_int(32'h0000_0008, "irq3 second int", 10, n);
        respond(1'b1, 1'b0, "irq3 second");
        check("irq3 final pending", irq_pending, 32'd0);
        check("irq3 final busy", 32'(busy), 32'd0);

        // Round-robin order and pointer wrap
        do_reset();
        pulse_irq(32'h8000_0021);
        wait_int(32'h0000_0001, "rr first", 10, n);
        respond(1'b1, 1'b0, "rr first");
        wait_int(32'h0000_0020, "rr second", 10, n);
        respond(1'b1, 1'b0, "rr second");
        wait_int(32'h8000_0000, "rr third", 10, n);
        respond(1'b1, 1'b0, "rr third");
        pulse_irq(32'h0000_0021);
        wait_int(32'h0000_0001, "rr wrap first", 10, n);
        respond(1'b1, 1'b0, "rr wrap first");
        wait_int(32'h0000_0020, "rr wrap second", 10, n);
        respond(1'b1, 1'b0, "rr wrap second");
        check("rr idle pending", irq_pending, 32'd0);

        // Fail -> backoff -> retry of the same vector
        pulse_irq(32'h0000_0004);
        wait_int(32'h0000_0004, "fail int", 10, n);
        respond(1'b0, 1'b1, "fail");
        check("fail pending re-set", irq_pending, 32'h0000_0004);
        check("fail busy", 32'(busy), 32'd1);
        quiet(RETRY_DELAY, "backoff quiet");
        wait_int(32'h0000_0004, "retry int", 10, n);
        tot = RETRY_DELAY + n;
        // RETRY_DELAY backoff cycles plus one IDLE select cycle
        check("retry gap", 32'(tot), 32'(RETRY_DELAY + 1));
        respond(1'b1, 1'b0, "retry");
        check("retry pending", irq_pending, 32'd0);

        // Vector folding with 2 allocated vectors; sent+fail counts as sent
        msi.cfg_interrupt_msi_mmenable = 12'd1;
        pulse_irq(32'h0000_0040);
        check("fold6 pending", irq_pending, 32'h0000_0001);
        wait_int(32'h0000_0001, "fold6 int", 10, n);
        respond(1'b1, 1'b0, "fold6");
        pulse_irq(32'h0000_0080);
        wait_int(32'h0000_0002, "fold7 int", 10, n);
        respond(1'b1, 1'b1, "fold7");
        check("sent+fail pending", irq_pending, 32'd0);
        check("sent+fail busy", 32'(busy), 32'd0);

        // Disabled MSI holds pending; then timeout retry path
        msi.cfg_interrupt_msi_mmenable = 12'd5;
        msi.cfg_interrupt_msi_enable   = 4'h0;
        pulse_irq(32'h0000_0010);
        quiet(10, "disabled quiet");
        check("disabled pending", irq_pending, 32'h0000_0010);
        check("disabled busy", 32'(busy), 32'd0);
        msi.cfg_interrupt_msi_enable = 4'h1;
        wait_int(32'h0000_0010, "enable int", 10, n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == SENT_TIMEOUT + 4) begin
                check("timeout pending re-set", irq_pending, 32'h0000_0010);
                check("timeout busy", 32'(busy), 32'd1);
            end
        end while (msi.cfg_interrupt_msi_int == 32'd0 && n < SENT_TIMEOUT + RETRY_DELAY + 50);
        check("timeout retry int", msi.cfg_interrupt_msi_int, 32'h0000_0010);
        // int cycle, 4096 WAIT cycles, 64 BACKOFF cycles, one IDLE cycle
        check("timeout retry gap", 32'(n), 32'(SENT_TIMEOUT + RETRY_DELAY + 2));
        respond(1'b1, 1'b0, "timeout retry");
        check("timeout final pending", irq_pending, 32'd0);
        check("timeout final busy", 32'(busy), 32'd0);

`ifdef PCIE_MSI_MASK_EN
        // Masked vector stays pending until unmasked
        do_reset();
        msi.cfg_interrupt_msi_data        = 32'h0000_0002;
        msi.cfg_interrupt_msi_mask_update = 1'b1;
        @(negedge clk);
        msi.cfg_interrupt_msi_mask_update = 1'b0;
        repeat (3) @(negedge clk);
        pulse_irq(32'h0000_0002);
        quiet(10, "masked quiet");
        check("masked pending", irq_pending, 32'h0000_0002);
        msi.cfg_interrupt_msi_data        = 32'h0000_0000;
        msi.cfg_interrupt_msi_mask_update = 1'b1;
        @(negedge clk);
        msi.cfg_interrupt_msi_mask_update = 1'b0;
        wait_int(32'h0000_0002, "unmasked int", 10, n);
        respond(1'b1, 1'b0, "unmasked");
        check("unmasked pending", irq_pending, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
